chnlnk_frame_rx: RTL and testbench

- Receive-side deframer for the DCFEB channel-link frame stream.
- Accepts the 100-word frames produced by the channel-link transmitter: 96 sample words, then 4 tail words.
- Word 99 carries the CRC-16 of words 0..98.
- Steers sample words to a sample buffer write port and tail words to a tail port, checks frame length and CRC, detects end-of-event, and keeps frame/error counters for the slow-control readback.

---
 rtl/chnlnk_frame_rx.sv | 152 +++++++++++++++
 tb/tb_chnlnk_frame_rx.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/chnlnk_frame_rx.sv
// Receive deframer for the DCFEB channel-link stream: splits 100-word frames into
// sample/tail write ports, checks frame length and CRC-16, and counts frames and errors.
module chnlnk_frame_rx #(
   parameter int          DATA_W   = 16,
   parameter int          NSAMP    = 96,
   parameter int          NTAIL    = 4,
   parameter logic [15:0] CRC_POLY = 16'h8005
) (
   input  logic              CLK,
   input  logic              RST_N,
   input  logic [DATA_W-1:0] DIN,
   input  logic              DIN_VALID,
   input  logic              DIN_LAST,
   output logic [DATA_W-1:0] SMP_DATA,
   output logic              SMP_WE,
   output logic [6:0]        SMP_IDX,
   output logic [DATA_W-1:0] TAIL_DATA,
   output logic              TAIL_WE,
   output logic [1:0]        TAIL_IDX,
   output logic              FRM_DONE,
   output logic              FRM_CRC_ERR,
   output logic              FRM_LEN_ERR,
   output logic              EVT_DONE,
   output logic [7:0]        FRM_CNT,
   output logic [7:0]        ERR_CNT,
   output logic [2:0]        RX_STATE
);

   localparam int NWORD = NSAMP + NTAIL;

   localparam logic [2:0] S_IDLE   = 3'b000;
   localparam logic [2:0] S_SAMPLE = 3'b001;
   localparam logic [2:0] S_TAIL   = 3'b010;
   localparam logic [2:0] S_CHECK  = 3'b011;
   localparam logic [2:0] S_ABORT  = 3'b100;

   localparam logic [6:0] LAST_SMP  = 7'(NSAMP - 1);
   localparam logic [6:0] LAST_WORD = 7'(NWORD - 1);
   localparam logic [6:0] TAIL_BASE = 7'(NSAMP);

   logic [2:0]  state, state_nxt;
   logic [6:0]  wcnt;
   logic [15:0] crc, crc_ref;

   logic       in_body, take_first, take_body, len_err_ev, chk_ev;
   logic       smp_wr, tail_wr, crc_err;
   logic [8:0] err_sum;

   // MSB-first CRC over one full word; init and final XOR are handled by the caller.
   function automatic logic [15:0] crc_step(input logic [15:0] c, input logic [DATA_W-1:0] d);
      logic [15:0] r;
      logic        fb;
      r = c;
      for (int i = DATA_W - 1; i >= 0; i--) begin
         fb = r[15] ^ d[i];
         r  = {r[14:0], 1'b0} ^ (fb ? CRC_POLY : 16'h0000);
      end
      return r;
   endfunction

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) state <= S_IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = S_IDLE;
      case (state)
         S_IDLE:   state_nxt = DIN_VALID ? S_SAMPLE : S_IDLE;
         S_SAMPLE: if (len_err_ev)            state_nxt = S_ABORT;
                   else if (wcnt == LAST_SMP) state_nxt = S_TAIL;
                   else                       state_nxt = S_SAMPLE;
         S_TAIL:   if (len_err_ev)             state_nxt = S_ABORT;
                   else if (wcnt == LAST_WORD) state_nxt = S_CHECK;
                   else                        state_nxt = S_TAIL;
         S_CHECK:  state_nxt = DIN_VALID ? S_SAMPLE : S_IDLE;
         S_ABORT:  state_nxt = S_IDLE;
         default:  state_nxt = S_IDLE;
      endcase
   end

   // Control decode. A word in Check opens the next frame, so Idle and Check share take_first.
   always_comb begin
      in_body    = (state == S_SAMPLE) || (state == S_TAIL);
      take_first = ((state == S_IDLE) || (state == S_CHECK)) && DIN_VALID;
      take_body  = in_body && DIN_VALID && !DIN_LAST;
      len_err_ev = in_body && !take_body;
      chk_ev     = (state == S_CHECK);
      smp_wr     = take_first || (take_body && (state == S_SAMPLE));
      tail_wr    = take_body && (state == S_TAIL);
      crc_err    = (crc != crc_ref);
      err_sum    = {1'b0, ERR_CNT} + 9'(chk_ev && crc_err) + 9'(len_err_ev);
   end

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         wcnt    <= '0;
         crc     <= '0;
         crc_ref <= '0;
      end else begin
         if (take_first)     wcnt <= 7'd1;
         else if (take_body) wcnt <= wcnt + 7'd1;
         else                wcnt <= '0;

         // The last word carries the CRC itself, so it is latched rather than folded in.
         if (take_first)
            crc <= crc_step(16'h0000, DIN);
         else if (take_body && (wcnt != LAST_WORD))
            crc <= crc_step(crc, DIN);

         if (tail_wr && (wcnt == LAST_WORD))
            crc_ref <= DIN[15:0];
      end
   end

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         SMP_DATA    <= '0;
         SMP_WE      <= 1'b0;
         SMP_IDX     <= '0;
         TAIL_DATA   <= '0;
         TAIL_WE     <= 1'b0;
         TAIL_IDX    <= '0;
         FRM_DONE    <= 1'b0;
         FRM_CRC_ERR <= 1'b0;
         FRM_LEN_ERR <= 1'b0;
         EVT_DONE    <= 1'b0;
         FRM_CNT     <= '0;
         ERR_CNT     <= '0;
      end else begin
         SMP_WE <= smp_wr;
         if (smp_wr) begin
            SMP_DATA <= DIN;
            SMP_IDX  <= take_first ? 7'd0 : wcnt;
         end
         TAIL_WE <= tail_wr;
         if (tail_wr) begin
            TAIL_DATA <= DIN;
            TAIL_IDX  <= 2'(wcnt - TAIL_BASE);
         end
         FRM_DONE    <= chk_ev;
         FRM_CRC_ERR <= chk_ev && crc_err;
         EVT_DONE    <= chk_ev && DIN_LAST;
         FRM_LEN_ERR <= len_err_ev;
         FRM_CNT     <= FRM_CNT + 8'(chk_ev);
         ERR_CNT     <= err_sum[8] ? 8'hFF : err_sum[7:0];
      end
   end

   assign RX_STATE = state;

endmodule

// File: tb/tb_chnlnk_frame_rx.sv
// Randomized bench for chnlnk_frame_rx against a transaction-level frame model.
module tb_chnlnk_frame_rx;

   logic        CLK = 1'b0;
   logic        RST_N = 1'b0;
   logic [15:0] DIN = '0;
   logic        DIN_VALID = 1'b0;
   logic        DIN_LAST = 1'b0;
   logic [15:0] SMP_DATA, TAIL_DATA;
   logic        SMP_WE, TAIL_WE, FRM_DONE, FRM_CRC_ERR, FRM_LEN_ERR, EVT_DONE;
   logic [6:0]  SMP_IDX;
   logic [1:0]  TAIL_IDX;
   logic [7:0]  FRM_CNT, ERR_CNT;
   logic [2:0]  RX_STATE;

   chnlnk_frame_rx dut (
      .CLK(CLK), .RST_N(RST_N), .DIN(DIN), .DIN_VALID(DIN_VALID), .DIN_LAST(DIN_LAST),
      .SMP_DATA(SMP_DATA), .SMP_WE(SMP_WE), .SMP_IDX(SMP_IDX),
      .TAIL_DATA(TAIL_DATA), .TAIL_WE(TAIL_WE), .TAIL_IDX(TAIL_IDX),
      .FRM_DONE(FRM_DONE), .FRM_CRC_ERR(FRM_CRC_ERR), .FRM_LEN_ERR(FRM_LEN_ERR),
      .EVT_DONE(EVT_DONE), .FRM_CNT(FRM_CNT), .ERR_CNT(ERR_CNT), .RX_STATE(RX_STATE)
   );

   always #5 CLK = ~CLK;

   int cyc = 0;
   always @(posedge CLK) cyc <= cyc + 1;

   int n_cmp = 0, n_bad = 0, n_smp = 0, n_tail = 0;
   logic [63:0] q_smp[$], q_tail[$], q_done[$], q_len[$];
   logic [7:0]  exp_frm = '0, exp_err = '0;
   bit          carry_last = 1'b0;
   logic [15:0] frm [100];

   wire logic [95:0] outs_all = {30'd0, SMP_DATA, SMP_WE, SMP_IDX, TAIL_DATA, TAIL_WE, TAIL_IDX,
                                 FRM_DONE, FRM_CRC_ERR, FRM_LEN_ERR, EVT_DONE, FRM_CNT, ERR_CNT, RX_STATE};

   task automatic chk(input string tag, input logic [95:0] got, input logic [95:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge CLK);
      #1;
   endtask

   // Remainder of M(x)*x^16 divided by P(x), with M = words 0..98 taken MSB first.
   function automatic logic [15:0] ref_crc();
      bit          m [1600];
      logic [16:0] p;
      logic [15:0] r;
      p = {1'b1, 16'h8005};
      for (int w = 0; w < 99; w++)
         for (int b = 0; b < 16; b++) m[w*16 + b] = frm[w][15-b];
      for (int i = 1584; i < 1600; i++) m[i] = 1'b0;
      for (int i = 0; i < 1584; i++)
         if (m[i]) for (int j = 0; j < 17; j++) m[i+j] ^= p[16-j];
      for (int b = 0; b < 16; b++) r[15-b] = m[1584 + b];
      return r;
   endfunction

   task automatic err_inc();
      if (exp_err != 8'hFF) exp_err++;
   endtask

   task automatic apply_reset(input string tag);
      DIN_VALID = 1'b0;
      DIN_LAST  = 1'b0;
      RST_N     = 1'b0;
      q_smp.delete(); q_tail.delete(); q_done.delete(); q_len.delete();
      exp_frm = '0; exp_err = '0; carry_last = 1'b0;
      #1;
      chk(tag, outs_all, 96'd0);
      step(); step();
      RST_N = 1'b1;
      step();
   endtask

   // kind: 0 good, 1 DIN_VALID gap at word 'at', 2 DIN_LAST at word 'at', 3 reset at word 'at'
   task automatic run_frame(input int kind, input int at, input bit last_flag,
                            input bit corrupt, input bit b2b);
      for (int w = 0; w < 99; w++) frm[w] = 16'($urandom);
      frm[99] = ref_crc();
      if (corrupt) frm[37][0] = ~frm[37][0];
      for (int w = 0; w < 100; w++) begin
         if (kind == 3 && w == at) begin
            apply_reset("rst_mid_outputs");
            return;
         end
         if (kind != 0 && w == at) begin
            DIN       = 16'($urandom);
            DIN_VALID = (kind == 2);
            DIN_LAST  = (kind == 2);
            err_inc();
            q_len.push_back({32'(cyc + 1), 21'd0, exp_err, 3'd4});
            step();
            DIN       = 16'($urandom);
            DIN_VALID = 1'($urandom);
            DIN_LAST  = 1'($urandom);
            step();
            DIN_VALID = 1'b0;
            DIN_LAST  = 1'b0;
            carry_last = 1'b0;
            return;
         end
         DIN       = frm[w];
         DIN_VALID = 1'b1;
         DIN_LAST  = (w == 0) ? carry_last : 1'b0;
         if (w == 0) carry_last = 1'b0;
         if (w < 96) q_smp.push_back({32'(cyc + 1), 9'd0, 7'(w), frm[w]});
         else        q_tail.push_back({32'(cyc + 1), 14'd0, 2'(w - 96), frm[w]});
         step();
      end
      exp_frm++;
      if (corrupt) err_inc();
      q_done.push_back({32'(cyc + 1), 14'd0, corrupt, last_flag, exp_frm, exp_err});
      if (b2b) begin
         DIN_LAST   = last_flag;
         carry_last = last_flag;
      end else begin
         DIN_VALID = 1'b0;
         DIN_LAST  = last_flag;
         step();
         DIN_LAST  = 1'b0;
      end
   endtask

   always @(negedge CLK) begin
      logic [63:0] obs;
      if (SMP_WE) begin
         n_smp++;
         obs = {32'(cyc), 9'd0, SMP_IDX, SMP_DATA};
         if (q_smp.size() == 0) chk("smp_unexpected", obs, 0);
         else                   chk("smp_write", obs, q_smp.pop_front());
      end
      if (TAIL_WE) begin
         n_tail++;
         obs = {32'(cyc), 14'd0, TAIL_IDX, TAIL_DATA};
         if (q_tail.size() == 0) chk("tail_unexpected", obs, 0);
         else                    chk("tail_write", obs, q_tail.pop_front());
      end
      if (FRM_DONE) begin
         obs = {32'(cyc), 14'd0, FRM_CRC_ERR, EVT_DONE, FRM_CNT, ERR_CNT};
         if (q_done.size() == 0) chk("done_unexpected", obs, 0);
         else                    chk("frame_done", obs, q_done.pop_front());
      end else if (FRM_CRC_ERR || EVT_DONE) begin
         chk("orphan_pulse", {FRM_CRC_ERR, EVT_DONE}, 0);
      end
      if (FRM_LEN_ERR) begin
         obs = {32'(cyc), 21'd0, ERR_CNT, RX_STATE};
         if (q_len.size() == 0) chk("len_err_unexpected", obs, 0);
         else                   chk("len_err", obs, q_len.pop_front());
      end
   end

   initial begin
      int s0, t0, kind, at;
      bit b2b;

      apply_reset("reset_outputs");

      // Good frame closing the event.
      s0 = n_smp; t0 = n_tail;
      run_frame(0, 0, 1'b1, 1'b0, 1'b0);
      step();
      chk("good_smp_count", 96'(n_smp - s0), 96'd96);
      chk("good_tail_count", 96'(n_tail - t0), 96'd4);
      chk("good_frm_cnt", 96'(FRM_CNT), 96'd1);
      chk("good_err_cnt", 96'(ERR_CNT), 96'd0);

      // Two-frame event, then CRC corruption.
      run_frame(0, 0, 1'b0, 1'b0, 1'b0);
      run_frame(0, 0, 1'b1, 1'b0, 1'b0);
      run_frame(0, 0, 1'b0, 1'b1, 1'b0);
      step();
      chk("crc_frm_cnt", 96'(FRM_CNT), 96'd4);
      chk("crc_err_cnt", 96'(ERR_CNT), 96'd1);

      // Gap at word 50 and early DIN_LAST at word 40.
      s0 = n_smp;
      run_frame(1, 50, 1'b0, 1'b0, 1'b0);
      #3;
      chk("gap_idle_after_abort", 96'(RX_STATE), 96'd0);
      chk("gap_smp_count", 96'(n_smp - s0), 96'd50);
      step();
      s0 = n_smp;
      run_frame(2, 40, 1'b0, 1'b0, 1'b0);
      #3;
      chk("last_idle_after_abort", 96'(RX_STATE), 96'd0);
      chk("last_smp_count", 96'(n_smp - s0), 96'd40);
      step();

      // Back-to-back frames, then reset mid-frame and recovery.
      run_frame(0, 0, 1'b0, 1'b0, 1'b1);
      run_frame(0, 0, 1'b1, 1'b0, 1'b0);
      run_frame(3, 70, 1'b0, 1'b0, 1'b0);
      chk("rst_mid_frm_cnt", 96'(FRM_CNT), 96'd0);
      run_frame(0, 0, 1'b1, 1'b0, 1'b0);

      // Randomized mix of good, corrupt, aborted and back-to-back frames.
      for (int i = 0; i < 30; i++) begin
         kind = 0; at = 0; b2b = 1'b0;
         if ($urandom_range(0, 9) < 2) begin
            kind = $urandom_range(1, 2);
            at   = $urandom_range(1, 99);
         end else begin
            b2b = (i != 29) && 1'($urandom);
         end
         run_frame(kind, at, 1'($urandom), (kind == 0) && ($urandom_range(0, 4) == 0), b2b);
         if (!b2b) begin
            for (int g = $urandom_range(0, 2); g > 0; g--) begin
               DIN_LAST = 1'($urandom);
               step();
            end
            DIN_LAST = 1'b0;
         end
      end
      step(); step();
      chk("rand_frm_cnt", 96'(FRM_CNT), 96'(exp_frm));
      chk("rand_err_cnt", 96'(ERR_CNT), 96'(exp_err));

      // 260 CRC-bad frames from reset: FRM_CNT wraps, ERR_CNT saturates.
      apply_reset("reset_before_sat");
      for (int i = 0; i < 260; i++)
         run_frame(0, 0, 1'($urandom), 1'b1, (i != 259) && 1'($urandom));
      step(); step(); step();
      chk("sat_frm_cnt", 96'(FRM_CNT), 96'd4);
      chk("sat_err_cnt", 96'(ERR_CNT), 96'd255);
      chk("q_smp_drained", 96'(q_smp.size()), 96'd0);
      chk("q_tail_drained", 96'(q_tail.size()), 96'd0);
      chk("q_done_drained", 96'(q_done.size()), 96'd0);
      chk("q_len_drained", 96'(q_len.size()), 96'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
